// File: rtl/freq_div_gen.sv
// ---------------------------------------------------------------------------
// freq_div_gen
//
// Programmable frequency divider. The divisor comes either from a fixed
// 8-entry table indexed by a 3-bit frequency code, or directly from an
// external input. Each half-period of the output square wave lasts
// Div_Act + 1 enabled clocks. A one-cycle Tick marks every 0->1 transition
// of the output.
//
// Parameters:
//   DIV_W   divisor / counter width. Must be >= 7 so that 79 fits.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET    in   asynchronous active-high reset
//   EN       in   count enable; when low, all state holds (Tick drops)
//   Restart  in   synchronous phase restart strobe (takes priority over EN)
//   Mode     in   divisor source: 0 = table[Frec], 1 = Div_Ext
//   Frec     in   3-bit frequency code (Mode = 0)
//   Div_Ext  in   external divisor (Mode = 1)
//   Clk_Out  out  divided square wave, registered
//   Tick     out  one-cycle pulse on each rising edge of Clk_Out, registered
//   Div_Act  out  divisor currently in use, registered
// ---------------------------------------------------------------------------
module freq_div_gen #(
    parameter int DIV_W = 7
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             Restart,
    input  logic             Mode,
    input  logic [2:0]       Frec,
    input  logic [DIV_W-1:0] Div_Ext,
    output logic             Clk_Out,
    output logic             Tick,
    output logic [DIV_W-1:0] Div_Act
);

    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(79);

    logic [DIV_W-1:0] table_div;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] div_act_reg;
    logic             clk_out_reg;
    logic             tick_reg;

    // Frequency code to divisor constant.
    always_comb begin
        table_div = DIV_RESET;
        case (Frec)
            3'b000:  table_div = DIV_W'(79);
            3'b001:  table_div = DIV_W'(47);
            3'b010:  table_div = DIV_W'(31);
            3'b011:  table_div = DIV_W'(23);
            3'b100:  table_div = DIV_W'(19);
            3'b101:  table_div = DIV_W'(15);
            3'b110:  table_div = DIV_W'(13);
            3'b111:  table_div = DIV_W'(11);
            default: table_div = DIV_RESET;
        endcase
    end

    // Candidate divisor; only latched into div_act_reg when the counter is
    // cleared, so a half-period in progress always finishes on the old value.
    assign div_next = Mode ? Div_Ext : table_div;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
            div_act_reg <= DIV_RESET;
        end else if (Restart) begin
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
            div_act_reg <= div_next;
        end else if (!EN) begin
            tick_reg    <= 1'b0;
        end else if (cnt_reg == div_act_reg) begin
            // Half-period boundary: toggle, retune, and flag a rising edge
            // (old output low means the new one is high).
            cnt_reg     <= '0;
            clk_out_reg <= ~clk_out_reg;
            tick_reg    <= ~clk_out_reg;
            div_act_reg <= div_next;
        end else begin
            cnt_reg     <= cnt_reg + DIV_W'(1);
            tick_reg    <= 1'b0;
        end
    end

    assign Clk_Out = clk_out_reg;
    assign Tick    = tick_reg;
    assign Div_Act = div_act_reg;

endmodule

// File: tb/tb_freq_div_gen.sv
// ---------------------------------------------------------------------------
// tb_freq_div_gen
//
// Bench for freq_div_gen with DIV_W = 8. Expected Tick edge numbers are
// pushed to a queue when each scenario's stimulus is set up, and popped as
// Tick pulses appear. Edge numbers count rising CLK edges after the reset
// release or Restart edge (edge 0) of each scenario.
// ---------------------------------------------------------------------------
module tb_freq_div_gen;

    localparam int DIV_W = 8;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             EN;
    logic             Restart;
    logic             Mode;
    logic [2:0]       Frec;
    logic [DIV_W-1:0] Div_Ext;
    logic             Clk_Out;
    logic             Tick;
    logic [DIV_W-1:0] Div_Act;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    freq_div_gen #(.DIV_W(DIV_W)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .EN      (EN),
        .Restart (Restart),
        .Mode    (Mode),
        .Frec    (Frec),
        .Div_Ext (Div_Ext),
        .Clk_Out (Clk_Out),
        .Tick    (Tick),
        .Div_Act (Div_Act)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        int n = 0;
        RESET = 1'b1; EN = 1'b0; Restart = 1'b0; Mode = 1'b0; Frec = 3'b000; Div_Ext = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (Clk_Out !== 1'b0 || Tick !== 1'b0 || Div_Act !== 8'd79) begin
            n_fail++;
            $display("FAIL reset_values: got clk=%b tick=%b div=%0d, want 0/0/79", Clk_Out, Tick, Div_Act);
        end
        exp_q.push_back(80); exp_q.push_back(240); exp_q.push_back(400);
        RESET = 1'b0; EN = 1'b1;
        while (n < 401) begin
            @(posedge CLK); #1; n++;
            if (Tick) begin
                $display("reset_run: tick at edge %0d", n);
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0] != n) begin
                    n_fail++;
                    $display("FAIL reset_run_tick: tick at edge %0d, want edge %0d", n, (exp_q.size() != 0) ? exp_q[0] : -1);
                end else void'(exp_q.pop_front());
            end
            if (n == 79 || n == 80 || n == 159 || n == 160) begin
                n_checks++;
                if (Clk_Out !== ((n == 80 || n == 159) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL reset_run_clk: edge %0d clk_out=%b", n, Clk_Out);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_run_missed: %0d ticks missing, next want edge %0d", exp_q.size(), exp_q[0]);
        end
        exp_q.delete();
    endtask

    task automatic test_retune();
        int n = 0;
        Mode = 1'b0; Frec = 3'b000; EN = 1'b1;
        Restart = 1'b1; @(posedge CLK); #1; Restart = 1'b0;
        exp_q.push_back(80); exp_q.push_back(172); exp_q.push_back(196); exp_q.push_back(220);
        while (n < 225) begin
            @(posedge CLK); #1; n++;
            if (n == 110) Frec = 3'b111;
            if (Tick) begin
                $display("retune: tick at edge %0d", n);
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0] != n) begin
                    n_fail++;
                    $display("FAIL retune_tick: tick at edge %0d, want edge %0d", n, (exp_q.size() != 0) ? exp_q[0] : -1);
                end else void'(exp_q.pop_front());
            end
            if (n == 159 || n == 160) begin
                n_checks++;
                if (Clk_Out !== (n == 159) || Div_Act !== ((n == 159) ? 8'd79 : 8'd11)) begin
                    n_fail++;
                    $display("FAIL retune_boundary: edge %0d clk=%b div=%0d", n, Clk_Out, Div_Act);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL retune_missed: %0d ticks missing, next want edge %0d", exp_q.size(), exp_q[0]);
        end
        exp_q.delete();
    endtask

    task automatic test_ext();
        int n = 0;
        Mode = 1'b1; Div_Ext = 8'd0; EN = 1'b1;
        Restart = 1'b1; @(posedge CLK); #1; Restart = 1'b0;
        for (int k = 1; k < 10; k += 2) exp_q.push_back(k);
        while (n < 10) begin
            @(posedge CLK); #1; n++;
            if (Tick) begin
                $display("ext0: tick at edge %0d", n);
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0] != n) begin
                    n_fail++;
                    $display("FAIL ext0_tick: tick at edge %0d, want edge %0d", n, (exp_q.size() != 0) ? exp_q[0] : -1);
                end else void'(exp_q.pop_front());
            end
            n_checks++;
            if (Clk_Out !== n[0]) begin
                n_fail++;
                $display("FAIL ext0_clk: edge %0d clk_out=%b want %b", n, Clk_Out, n[0]);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ext0_missed: %0d ticks missing", exp_q.size());
        end
        exp_q.delete();

        n = 0;
        Div_Ext = 8'd255;
        Restart = 1'b1; @(posedge CLK); #1; Restart = 1'b0;
        n_checks++;
        if (Div_Act !== 8'd255) begin
            n_fail++;
            $display("FAIL ext255_div: div_act=%0d want 255", Div_Act);
        end
        exp_q.push_back(256); exp_q.push_back(768);
        while (n < 770) begin
            @(posedge CLK); #1; n++;
            if (Tick) begin
                $display("ext255: tick at edge %0d", n);
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0] != n) begin
                    n_fail++;
                    $display("FAIL ext255_tick: tick at edge %0d, want edge %0d", n, (exp_q.size() != 0) ? exp_q[0] : -1);
                end else void'(exp_q.pop_front());
            end
            if (n == 255 || n == 256 || n == 511 || n == 512) begin
                n_checks++;
                if (Clk_Out !== ((n == 256 || n == 511) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL ext255_clk: edge %0d clk_out=%b", n, Clk_Out);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ext255_missed: %0d ticks missing", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_en_gap();
        int n = 0;
        Mode = 1'b0; Frec = 3'b101; EN = 1'b1;
        Restart = 1'b1; @(posedge CLK); #1; Restart = 1'b0;
        exp_q.push_back(16); exp_q.push_back(55);
        while (n < 56) begin
            @(posedge CLK); #1; n++;
            if (n == 20) EN = 1'b0;
            if (n == 27) EN = 1'b1;
            if (Tick) begin
                $display("en_gap: tick at edge %0d", n);
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0] != n) begin
                    n_fail++;
                    $display("FAIL en_gap_tick: tick at edge %0d, want edge %0d", n, (exp_q.size() != 0) ? exp_q[0] : -1);
                end else void'(exp_q.pop_front());
            end
            if (n >= 21 && n <= 27) begin
                n_checks++;
                if (Clk_Out !== 1'b1 || Tick !== 1'b0 || Div_Act !== 8'd15) begin
                    n_fail++;
                    $display("FAIL en_gap_frozen: edge %0d clk=%b tick=%b div=%0d", n, Clk_Out, Tick, Div_Act);
                end
            end
            if (n == 38 || n == 39) begin
                n_checks++;
                if (Clk_Out !== (n == 38)) begin
                    n_fail++;
                    $display("FAIL en_gap_fall: edge %0d clk_out=%b", n, Clk_Out);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL en_gap_missed: %0d ticks missing", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_restart_tc();
        int n = 0;
        Mode = 1'b0; Frec = 3'b111; EN = 1'b1;
        Restart = 1'b1; @(posedge CLK); #1; Restart = 1'b0;
        exp_q.push_back(44);
        while (n < 45) begin
            @(posedge CLK); #1; n++;
            if (n == 11) begin
                Restart = 1'b1; Frec = 3'b010;
            end
            if (n == 12) begin
                Restart = 1'b0;
                n_checks++;
                if (Clk_Out !== 1'b0 || Tick !== 1'b0 || Div_Act !== 8'd31) begin
                    n_fail++;
                    $display("FAIL restart_tc: clk=%b tick=%b div=%0d, want 0/0/31", Clk_Out, Tick, Div_Act);
                end
            end
            if (Tick) begin
                $display("restart_tc: tick at edge %0d", n);
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0] != n) begin
                    n_fail++;
                    $display("FAIL restart_tc_tick: tick at edge %0d, want edge %0d", n, (exp_q.size() != 0) ? exp_q[0] : -1);
                end else void'(exp_q.pop_front());
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL restart_tc_missed: %0d ticks missing", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        int n = 0;
        Mode = 1'b0; Frec = 3'b110; EN = 1'b1;
        Restart = 1'b1; @(posedge CLK); #1; Restart = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        n_checks++;
        if (Clk_Out !== 1'b1 || Div_Act !== 8'd13) begin
            n_fail++;
            $display("FAIL pre_reset: clk=%b div=%0d, want 1/13", Clk_Out, Div_Act);
        end
        #2 RESET = 1'b1;
        #1;
        n_checks++;
        if (Clk_Out !== 1'b0 || Tick !== 1'b0 || Div_Act !== 8'd79) begin
            n_fail++;
            $display("FAIL async_reset: clk=%b tick=%b div=%0d, want 0/0/79", Clk_Out, Tick, Div_Act);
        end
        #2 RESET = 1'b0;
        exp_q.push_back(80);
        while (n < 81) begin
            @(posedge CLK); #1; n++;
            if (Tick) begin
                $display("async_reset: tick at edge %0d", n);
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0] != n) begin
                    n_fail++;
                    $display("FAIL async_reset_tick: tick at edge %0d, want edge %0d", n, (exp_q.size() != 0) ? exp_q[0] : -1);
                end else void'(exp_q.pop_front());
            end
            if (n == 79 || n == 80) begin
                n_checks++;
                if (Clk_Out !== (n == 80)) begin
                    n_fail++;
                    $display("FAIL async_reset_rise: edge %0d clk_out=%b", n, Clk_Out);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL async_reset_missed: %0d ticks missing", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_retune();
        test_ext();
        test_en_gap();
        test_restart_tc();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
